// File: rtl/fifo_frame_packer.sv
// Pops FIFO words, groups FRAME_LEN of them into a valid/ready frame with sof/eof markers.
// Optional appended modular checksum word when FRAME_PACKER_CSUM_EN is defined.
module fifo_frame_packer #(
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 4,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sof,
  output logic              out_eof,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_SEND  = 2'd2;
`ifdef FRAME_PACKER_CSUM_EN
  localparam logic [1:0] S_CSUM  = 2'd3;
  logic [DATA_W-1:0] r_sum;
`endif

  logic [1:0]        r_state;
  logic [IDX_W-1:0]  r_idx;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_sof;
  logic              r_eof;
  logic [CNT_W-1:0]  r_cnt;

  logic w_hs;
  logic w_last;
  logic w_rd_en;

  assign w_hs   = r_valid && out_ready;
  assign w_last = (r_idx == LAST_IDX);

  // Pop is combinational so the FIFO data lands exactly in FETCH; in SEND it only
  // fires on the handshake that frees the output register.
  assign w_rd_en = !reset && !fifo_empty &&
                   ((r_state == S_IDLE) || ((r_state == S_SEND) && w_hs && !w_last));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sof   <= 1'b0;
      r_eof   <= 1'b0;
      r_cnt   <= '0;
`ifdef FRAME_PACKER_CSUM_EN
      r_sum   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!fifo_empty) r_state <= S_FETCH;
        end
        S_FETCH: begin
          r_data  <= fifo_rd_data;
          r_valid <= 1'b1;
          r_sof   <= (r_idx == '0);
`ifndef FRAME_PACKER_CSUM_EN
          r_eof   <= w_last;
`endif
          r_state <= S_SEND;
        end
        S_SEND: begin
          if (w_hs) begin
            r_valid <= 1'b0;
            r_sof   <= 1'b0;
            r_eof   <= 1'b0;
            if (w_last) begin
`ifdef FRAME_PACKER_CSUM_EN
              // Checksum word follows directly; the sum includes the word just accepted.
              r_sum   <= r_sum + r_data;
              r_data  <= r_sum + r_data;
              r_valid <= 1'b1;
              r_eof   <= 1'b1;
              r_state <= S_CSUM;
`else
              r_cnt   <= r_cnt + 1'b1;
              r_idx   <= '0;
              r_state <= S_IDLE;
`endif
            end else begin
`ifdef FRAME_PACKER_CSUM_EN
              r_sum   <= r_sum + r_data;
`endif
              r_idx   <= r_idx + 1'b1;
              r_state <= fifo_empty ? S_IDLE : S_FETCH;
            end
          end
        end
`ifdef FRAME_PACKER_CSUM_EN
        S_CSUM: begin
          if (w_hs) begin
            r_valid <= 1'b0;
            r_eof   <= 1'b0;
            r_cnt   <= r_cnt + 1'b1;
            r_idx   <= '0;
            r_sum   <= '0;
            r_state <= S_IDLE;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign fifo_rd_en = w_rd_en;
  assign out_valid  = r_valid;
  assign out_data   = r_data;
  assign out_sof    = r_sof;
  assign out_eof    = r_eof;
  assign frame_cnt  = r_cnt;

endmodule
